// File: rtl/mtl_sopc_mul_seq_if.sv
// Operand/result handshake bundle for mtl_sopc_mul_seq.
interface mtl_sopc_mul_seq_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_result, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_result, busy
  );
endinterface

// File: rtl/mtl_sopc_mul_seq.sv
// Sequential WIDTH x WIDTH multiplier iterating 16x16 limb products on one shared multiplier.
// Define MTL_MUL_HIGH_EN for the high-half ops (MULXUU/MULXSU/MULXSS); otherwise low half only.
//   state | meaning
//   IDLE  | ready for a request
//   CALC  | accumulate one limb product per cycle
//   CORR  | select half, apply sign correction, register result
//   DONE  | result valid, waiting for out_ready
module mtl_sopc_mul_seq #(parameter int WIDTH = 32) (
  input logic               clk,
  input logic               reset,
  mtl_sopc_mul_seq_if.slave bus
);
  localparam int L = WIDTH / 16;
`ifdef MTL_MUL_HIGH_EN
  localparam int ACC_W = 2 * WIDTH;
`else
  localparam int ACC_W = WIDTH;
`endif

  typedef enum logic [1:0] {IDLE, CALC, CORR, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [2:0]       i_q, i_d, j_q, j_d;

  logic [WIDTH-1:0] a_sh, b_sh;
  logic [15:0]      a_limb, b_limb;
  logic [31:0]      prod;
  logic [2:0]       ij_sum;
  logic [ACC_W-1:0] prod_sh;
  logic             j_last, i_last;
  logic [WIDTH-1:0] result;

`ifdef MTL_MUL_HIGH_EN
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] hi, sub_a, sub_b;
`else
  logic             op_unused;
  assign op_unused = ^bus.in_op;
`endif

  always_comb begin
    a_sh    = a_q >> {i_q, 4'b0};
    b_sh    = b_q >> {j_q, 4'b0};
    a_limb  = a_sh[15:0];
    b_limb  = b_sh[15:0];
    prod    = {16'b0, a_limb} * {16'b0, b_limb};
    ij_sum  = i_q + j_q;
    prod_sh = ACC_W'(prod) << {ij_sum, 4'b0};
    i_last  = (i_q == 3'(L - 1));
`ifdef MTL_MUL_HIGH_EN
    j_last  = (j_q == 3'(L - 1));
`else
    // Low-half build walks only the triangle i+j < L.
    j_last  = (ij_sum == 3'(L - 1));
`endif
  end

  always_comb begin
`ifdef MTL_MUL_HIGH_EN
    hi    = acc_q[2*WIDTH-1:WIDTH];
    sub_a = a_q[WIDTH-1] ? b_q : '0;
    sub_b = b_q[WIDTH-1] ? a_q : '0;
    case (op_q)
      2'b00:   result = acc_q[WIDTH-1:0];
      2'b01:   result = hi;
      2'b10:   result = hi - sub_a;
      default: result = hi - sub_a - sub_b;
    endcase
`else
    result = acc_q[WIDTH-1:0];
`endif
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    i_d     = i_q;
    j_d     = j_q;
    res_d   = res_q;
`ifdef MTL_MUL_HIGH_EN
    op_d    = op_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
`ifdef MTL_MUL_HIGH_EN
          op_d    = bus.in_op;
`endif
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_q + prod_sh;
        if (j_last) begin
          j_d = '0;
          i_d = i_q + 3'd1;
          if (i_last) state_d = CORR;
        end else begin
          j_d = j_q + 3'd1;
        end
      end
      CORR: begin
        res_d   = result;
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      res_q   <= '0;
`ifdef MTL_MUL_HIGH_EN
      op_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      j_q     <= j_d;
      res_q   <= res_d;
`ifdef MTL_MUL_HIGH_EN
      op_q    <= op_d;
`endif
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.out_result = res_q;
endmodule

// File: tb/tb_mtl_sopc_mul_seq.sv
// Self-checking bench for mtl_sopc_mul_seq (WIDTH=32); expectations follow MTL_MUL_HIGH_EN.
module tb_mtl_sopc_mul_seq;
`ifdef MTL_MUL_HIGH_EN
  localparam int P = 4;
`else
  localparam int P = 3;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   accept_cyc = 0;
  int   checks = 0;
  int   passed = 0;
  logic [31:0] exp_q[$];

  mtl_sopc_mul_seq_if #(.WIDTH(32)) bus ();

  mtl_sopc_mul_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] op);
`ifdef MTL_MUL_HIGH_EN
    logic [63:0] ea, eb, p;
    ea = {{32{a[31] & op[1]}}, a};
    eb = {{32{b[31] & (op == 2'b11)}}, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
`else
    logic [31:0] p;
    p = a * b;
    return p;
`endif
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                      input logic [31:0] exp);
    int n = 0;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_op = op;
    bus.in_valid = 1'b1;
    exp_q.push_back(exp);
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      $display("FAIL accept_timeout: in_ready=%b required 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    bus.in_valid = 1'b0;
    bus.in_a = $urandom;
    bus.in_b = $urandom;
    bus.in_op = 2'($urandom_range(0, 3));
  endtask

  task automatic collect(output logic [31:0] res, output int lat, output bit to);
    int n = 0;
    bus.out_ready = 1'b1;
    while (bus.out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    to  = (n >= 200);
    res = bus.out_result;
    lat = cyc - accept_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3 reset = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 ||
        bus.out_result !== 32'h0)
      $display("FAIL reset_state: valid=%b ready=%b busy=%b result=%h required 0 1 0 00000000",
               bus.out_valid, bus.in_ready, bus.busy, bus.out_result);
    else passed++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL idle_after_reset: ready=%b valid=%b required 1 0", bus.in_ready, bus.out_valid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_tab[4];
    logic [31:0] res, exp;
    int lat, prev;
    bit to;
`ifdef MTL_MUL_HIGH_EN
    exp_tab = '{32'h00000001, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000};
`else
    exp_tab = '{default: 32'h00000001};
`endif
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      prev = accept_cyc;
      send(32'hFFFFFFFF, 32'hFFFFFFFF, 2'(k), exp_tab[k]);
      if (k > 0) begin
        checks++;
        if (accept_cyc - prev != P + 3)
          $display("FAIL b2b_spacing[%0d]: got %0d required %0d", k, accept_cyc - prev, P + 3);
        else passed++;
      end
      collect(res, lat, to);
      exp = exp_q.pop_front();
      checks++;
      if (to || res !== exp)
        $display("FAIL b2b_result[%0d]: got %h required %h (timeout=%b)", k, res, exp, to);
      else passed++;
      checks++;
      if (lat != P + 1)
        $display("FAIL b2b_latency[%0d]: got %0d required %0d", k, lat, P + 1);
      else passed++;
    end
  endtask

  task automatic test_corners();
    logic [31:0] res, exp;
    int lat;
    bit to;
`ifdef MTL_MUL_HIGH_EN
    send(32'h80000000, 32'h80000000, 2'b11, 32'h40000000);
`else
    send(32'h80000000, 32'h80000000, 2'b11, 32'h00000000);
`endif
    collect(res, lat, to);
    exp = exp_q.pop_front();
    checks++;
    if (to || res !== exp) $display("FAIL corner_minmin: got %h required %h", res, exp);
    else passed++;
    send(32'h80000000, 32'h00000002, 2'b10, model(32'h80000000, 32'h00000002, 2'b10));
    collect(res, lat, to);
    exp = exp_q.pop_front();
    checks++;
    if (to || res !== exp) $display("FAIL corner_su: got %h required %h", res, exp);
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp, res;
    int n = 0, lat;
    bit to;
    bit bad = 0;
    bus.out_ready = 1'b0;
    send(32'h12345678, 32'h9ABCDEF0, 2'b01, model(32'h12345678, 32'h9ABCDEF0, 2'b01));
    while (bus.out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    exp = exp_q.pop_front();
    checks++;
    if (n >= 200) $display("FAIL bp_valid_timeout: out_valid=%b required 1", bus.out_valid);
    else passed++;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 3) begin
        bus.in_a = 32'd7;
        bus.in_b = 32'd9;
        bus.in_op = 2'b00;
        bus.in_valid = 1'b1;
        exp_q.push_back(model(32'd7, 32'd9, 2'b00));
      end
      if (bus.out_valid !== 1'b1 || bus.out_result !== exp || bus.in_ready !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) $display("FAIL bp_stable: valid=%b result=%h ready=%b required 1 %h 0",
                      bus.out_valid, bus.out_result, bus.in_ready, exp);
    else passed++;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL bp_release: ready=%b valid=%b required 1 0", bus.in_ready, bus.out_valid);
    else passed++;
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) $display("FAIL bp_new_accept: busy=%b required 1", bus.busy);
    else passed++;
    collect(res, lat, to);
    exp = exp_q.pop_front();
    checks++;
    if (to || res !== exp || lat != P + 1)
      $display("FAIL bp_next_result: got %h lat %0d required %h lat %0d", res, lat, exp, P + 1);
    else passed++;
  endtask

  task automatic test_reset_abort();
    logic [31:0] res, exp, dropped;
    int lat;
    bit to;
    bit seen = 0;
    bus.out_ready = 1'b1;
    send(32'd3, 32'd5, 2'b00, model(32'd3, 32'd5, 2'b00));
    dropped = exp_q.pop_back();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL abort_state: valid=%b ready=%b busy=%b required 0 1 0 (dropped %h)",
               bus.out_valid, bus.in_ready, bus.busy, dropped);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) $display("FAIL abort_no_result: out_valid seen 1 required 0");
    else passed++;
    send(32'd7, 32'd6, 2'b00, 32'h0000002A);
    collect(res, lat, to);
    exp = exp_q.pop_front();
    checks++;
    if (to || res !== exp) $display("FAIL abort_next: got %h required %h", res, exp);
    else passed++;
  endtask

  task automatic test_reset_mid_done();
    logic [31:0] exp;
    int n = 0;
    bus.out_ready = 1'b0;
    send(32'h00012345, 32'h00010000, 2'b00, 32'h23450000);
    exp = exp_q.pop_front();
    while (bus.out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200 || bus.out_result !== exp)
      $display("FAIL limb_shift: got %h required %h", bus.out_result, exp);
    else passed++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.out_result !== 32'h0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL reset_in_done: result=%h valid=%b ready=%b required 00000000 0 1",
               bus.out_result, bus.out_valid, bus.in_ready);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] a, b, res, exp;
    logic [1:0] op;
    int lat, errs = 0;
    bit to;
    for (int k = 0; k < 1000; k++) begin
      a  = $urandom;
      b  = $urandom;
      op = 2'($urandom_range(0, 3));
      send(a, b, op, model(a, b, op));
      collect(res, lat, to);
      exp = exp_q.pop_front();
      checks++;
      if (to || res !== exp || lat != P + 1) begin
        if (errs < 10)
          $display("FAIL random[%0d]: a=%h b=%h op=%0d got %h lat %0d required %h lat %0d",
                   k, a, b, op, res, lat, exp, P + 1);
        errs++;
      end else passed++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_back_to_back();
    test_corners();
    test_backpressure();
    test_reset_abort();
    test_reset_mid_done();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
